// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-port controller.
// The result record pairs a destination register with its data word.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_port_ctrl_if.sv
// Issue, hazard, ALU/MDU completion and A3 write-port signals of the writer-side controller.
// The slave modport is the controller; the master modport is its environment.
interface regfile_write_port_ctrl_if #(
  parameter int XLEN = regfile_pkg::XLEN
);
  import regfile_pkg::*;

  logic                  iss_valid;
  logic [REG_ADDR_W-1:0] iss_rd;
  logic                  iss_ready;
  logic [REG_ADDR_W-1:0] chk_a1;
  logic [REG_ADDR_W-1:0] chk_a2;
  logic                  haz1;
  logic                  haz2;
  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  mdu_valid;
  logic                  mdu_ready;
  logic [REG_ADDR_W-1:0] mdu_rd;
  logic [XLEN-1:0]       mdu_data;
  logic                  we3;
  logic [REG_ADDR_W-1:0] a3;
  logic [XLEN-1:0]       wd3;
  logic                  sb_err;

  modport master (
    output iss_valid, iss_rd, chk_a1, chk_a2,
    output alu_valid, alu_rd, alu_data, mdu_valid, mdu_rd, mdu_data,
    input  iss_ready, haz1, haz2, mdu_ready, we3, a3, wd3, sb_err
  );

  modport slave (
    input  iss_valid, iss_rd, chk_a1, chk_a2,
    input  alu_valid, alu_rd, alu_data, mdu_valid, mdu_rd, mdu_data,
    output iss_ready, haz1, haz2, mdu_ready, we3, a3, wd3, sb_err
  );

endinterface

// File: rtl/wb_result_fifo.sv
// Circular buffer of pending MDU results: wrap-around pointers plus an occupancy count.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module wb_result_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  wb_req_t push_data_i,
  input  logic    pop_i,
  output wb_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; the count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/regfile_write_port_ctrl.sv
// Owns register-file write port A3: busy scoreboard, ALU/MDU arbitration and hazard flags.
// ALU wins every cycle; MDU results wait in a small buffer and drain in arrival order.
module regfile_write_port_ctrl
  import regfile_pkg::*;
#(
  parameter int XLEN      = regfile_pkg::XLEN,
  parameter int MDU_DEPTH = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  regfile_write_port_ctrl_if.slave bus
);

  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  sb_err_q, sb_err_d;
  logic                  we3_q;
  logic [REG_ADDR_W-1:0] a3_q;
  logic [XLEN-1:0]       wd3_q;

  wb_req_t buf_head, mdu_req, sel_req;
  logic    buf_full, buf_empty, buf_push, buf_pop;
  logic    sel_valid, wr_en, iss_ok, iss_set, mdu_ok;

  assign mdu_req = '{rd: bus.mdu_rd, data: bus.mdu_data};

  wb_result_fifo #(.DEPTH(MDU_DEPTH)) u_mdu_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (buf_push),
    .push_data_i (mdu_req),
    .pop_i       (buf_pop),
    .head_o      (buf_head),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_valid = 1'b0;
    sel_req   = '0;
    buf_pop   = ~bus.alu_valid & ~buf_empty;
    if (bus.alu_valid) begin
      sel_valid = 1'b1;
      sel_req   = '{rd: bus.alu_rd, data: bus.alu_data};
    end else if (!buf_empty) begin
      sel_valid = 1'b1;
      sel_req   = buf_head;
    end else if (bus.mdu_valid) begin
      sel_valid = 1'b1;
      sel_req   = mdu_req;
    end
    // A full buffer still accepts when its head drains this cycle.
    mdu_ok   = ~buf_full | buf_pop;
    buf_push = bus.mdu_valid & mdu_ok & ~(~bus.alu_valid & buf_empty);
    wr_en    = sel_valid & (sel_req.rd != ZERO_REG);
    iss_ok   = (bus.iss_rd == ZERO_REG) | ~busy_q[bus.iss_rd];
    iss_set  = bus.iss_valid & iss_ok & (bus.iss_rd != ZERO_REG);
    sb_err_d = sb_err_q | (wr_en & ~busy_q[sel_req.rd]);
    // Clear first, then set: a same-cycle issue to the written reg keeps it busy.
    busy_d = busy_q;
    if (wr_en)   busy_d[sel_req.rd] = 1'b0;
    if (iss_set) busy_d[bus.iss_rd] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
      we3_q    <= wr_en;
      if (sel_valid) begin
        a3_q  <= sel_req.rd;
        wd3_q <= sel_req.data;
      end
    end
  end

  assign bus.iss_ready = ~rst_n | iss_ok;
  assign bus.mdu_ready = ~rst_n | mdu_ok;
  assign bus.haz1      = rst_n & (bus.chk_a1 != ZERO_REG) & busy_q[bus.chk_a1];
  assign bus.haz2      = rst_n & (bus.chk_a2 != ZERO_REG) & busy_q[bus.chk_a2];
  assign bus.we3       = we3_q;
  assign bus.a3        = a3_q;
  assign bus.wd3       = wd3_q;
  assign bus.sb_err    = sb_err_q;

endmodule

// File: tb/tb_regfile_write_port_ctrl.sv
// Directed bench for regfile_write_port_ctrl: expected writes are queued when results are
// driven and matched in order against every we3 pulse; a regfile model commits on negedge.
module tb_regfile_write_port_ctrl;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_write_port_ctrl_if #(.XLEN(32)) bus ();

  regfile_write_port_ctrl #(.XLEN(32), .MDU_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  wb_req_t     wq[$];
  logic [31:0] rf [32];

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [4:0] rd, input logic [31:0] data);
    wq.push_back('{rd: rd, data: data});
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b0;
    bus.mdu_valid = 1'b0;
  endtask

  // Scoreboard monitor and regfile model: every emitted write must be the next expected one.
  always @(negedge clk) begin
    if (bus.we3 === 1'b1) begin
      check("wr_expected", {63'd0, wq.size() != 0}, 64'd1);
      if (wq.size() != 0) begin
        wb_req_t e;
        e = wq.pop_front();
        check("wr_rd_data", {27'd0, bus.a3, bus.wd3}, {27'd0, e.rd, e.data});
      end
      if (bus.a3 != 5'd0) rf[bus.a3] = bus.wd3;
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd1;
    bus.chk_a1    = 5'd1;
    bus.chk_a2    = 5'd1;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd1;
    bus.alu_data  = 32'h1111_0001;
    bus.mdu_valid = 1'b0;
    bus.mdu_rd    = 5'd0;
    bus.mdu_data  = '0;

    // 1) Reset with ALU active: nothing written, combinational outputs in reset state.
    tick();
    tick();
    check("rst_we3",       bus.we3,       1'b0);
    check("rst_a3",        bus.a3,        5'd0);
    check("rst_wd3",       bus.wd3,       32'd0);
    check("rst_sb_err",    bus.sb_err,    1'b0);
    check("rst_iss_ready", bus.iss_ready, 1'b1);
    check("rst_mdu_ready", bus.mdu_ready, 1'b1);
    check("rst_haz1",      bus.haz1,      1'b0);
    check("rst_haz2",      bus.haz2,      1'b0);

    rst_n         = 1'b1;
    bus.alu_valid = 1'b0;
    #1;
    check("rel_haz1_clear", bus.haz1, 1'b0);
    tick();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1;
    exp_wr(5'd1, 32'h1111_0001);
    #1;
    check("rel_haz1_busy", bus.haz1, 1'b1);
    tick();
    bus.alu_valid = 1'b0;
    check("rel_first_we3", bus.we3, 1'b1);
    check("rel_first_a3",  bus.a3,  5'd1);
    check("rel_haz1_drop", bus.haz1, 1'b0);

    // 2) Issue rd=5, hazard, ALU completion, regfile readback after negedge.
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd5;
    tick();
    bus.iss_valid = 1'b0;
    bus.chk_a1    = 5'd5;
    #1;
    check("t2_haz1",      bus.haz1,      1'b1);
    check("t2_waw_ready", bus.iss_ready, 1'b0);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEAD_BEEF;
    exp_wr(5'd5, 32'hDEAD_BEEF);
    tick();
    bus.alu_valid = 1'b0;
    check("t2_we3",  bus.we3,  1'b1);
    check("t2_a3",   bus.a3,   5'd5);
    check("t2_wd3",  bus.wd3,  32'hDEAD_BEEF);
    check("t2_haz1", bus.haz1, 1'b0);
    @(negedge clk);
    #1;
    check("t2_rf5", rf[5], 32'hDEAD_BEEF);

    // 3) Collision: ALU rd=3 and MDU rd=7 in the same cycle.
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd3;
    tick();
    bus.iss_rd = 5'd7;
    tick();
    bus.iss_valid = 1'b0;
    bus.chk_a2    = 5'd7;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 32'hA3A3_0003;
    bus.mdu_valid = 1'b1;
    bus.mdu_rd    = 5'd7;
    bus.mdu_data  = 32'h7777_0007;
    exp_wr(5'd3, 32'hA3A3_0003);
    exp_wr(5'd7, 32'h7777_0007);
    #1;
    check("t3_haz2",       bus.haz2,      1'b1);
    check("t3_mdu_ready0", bus.mdu_ready, 1'b1);
    tick();
    idle();
    #1;
    check("t3_c1_a3",      bus.a3,        5'd3);
    check("t3_mdu_ready1", bus.mdu_ready, 1'b1);
    tick();
    check("t3_c2_we3", bus.we3, 1'b1);
    check("t3_c2_a3",  bus.a3,  5'd7);
    check("t3_c2_wd3", bus.wd3, 32'h7777_0007);
    tick();
    check("t3_idle_we3", bus.we3, 1'b0);
    check("t3_hold_a3",  bus.a3,  5'd7);

    // 4) Backpressure: four ALU cycles while the MDU offers rd=8,9,10.
    bus.iss_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      logic [4:0] rds [7];
      rds = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd13, 5'd14, 5'd15};
      bus.iss_rd = rds[i];
      tick();
    end
    bus.iss_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [4:0] alu_rds [4];
      logic       rdy_exp [4];
      alu_rds = '{5'd11, 5'd13, 5'd14, 5'd15};
      rdy_exp = '{1'b1, 1'b1, 1'b0, 1'b0};
      bus.alu_valid = 1'b1;
      bus.alu_rd    = alu_rds[i];
      bus.alu_data  = 32'hA100_0000 + 32'(i);
      bus.mdu_valid = 1'b1;
      bus.mdu_rd    = 5'd8 + 5'(i < 2 ? i : 2);
      bus.mdu_data  = 32'hD000_0000 + 32'(i < 2 ? i : 2);
      exp_wr(alu_rds[i], 32'hA100_0000 + 32'(i));
      #1;
      check($sformatf("t4_mdu_ready_%0d", i), bus.mdu_ready, rdy_exp[i]);
      tick();
    end
    bus.alu_valid = 1'b0;
    exp_wr(5'd8,  32'hD000_0000);
    exp_wr(5'd9,  32'hD000_0001);
    exp_wr(5'd10, 32'hD000_0002);
    #1;
    check("t4_ready_on_pop", bus.mdu_ready, 1'b1);
    tick();
    bus.mdu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_mdu_order_%0d", i), bus.a3, 5'd8 + 5'(i));
      tick();
    end
    check("t4_idle_we3", bus.we3, 1'b0);

    // 5) Register zero: never busy, never written, never hazardous.
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd0;
    #1;
    check("t5_iss_ready_r0", bus.iss_ready, 1'b1);
    tick();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'd1;
    tick();
    bus.alu_valid = 1'b0;
    bus.chk_a1    = 5'd0;
    #1;
    check("t5_we3_r0",   bus.we3,    1'b0);
    check("t5_haz1_r0",  bus.haz1,   1'b0);
    check("t5_sb_err_0", bus.sb_err, 1'b0);

    // 6) WAW block on busy reg 4, then a completion for never-issued rd=12.
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd4;
    tick();
    bus.iss_valid = 1'b0;
    #1;
    check("t6_waw", bus.iss_ready, 1'b0);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd12;
    bus.alu_data  = 32'hC0DE_0012;
    exp_wr(5'd12, 32'hC0DE_0012);
    tick();
    bus.alu_valid = 1'b0;
    check("t6_sb_err_set", bus.sb_err, 1'b1);
    check("t6_wr_a3",      bus.a3,     5'd12);
    tick();
    tick();
    check("t6_sb_err_held", bus.sb_err, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_sb_err_rst",  bus.sb_err,    1'b0);
    check("t6_busy4_clear", bus.iss_ready, 1'b1);
    tick();
    check("end_queue_empty", 64'(wq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
